// File: rtl/fsic_pkg.sv
// Shared FSIC definitions: reset sequencer states, reset-cause codes
// and the soft-reset requester priority encoder.
package fsic_pkg;

  typedef enum logic [2:0] {
    ST_SYNC      = 3'd0,
    ST_WAIT_IO   = 3'd1,
    ST_WAIT_CORE = 3'd2,
    ST_WAIT_USER = 3'd3,
    ST_RUN       = 3'd4,
    ST_HOLD      = 3'd5
  } rst_state_e;

  localparam int N_REQ = 4;

  localparam logic [2:0] CAUSE_POR = 3'b000;

  // Lowest set index wins; [0] is the highest priority requester.
  function automatic logic [1:0] prio_idx(
    input logic [N_REQ-1:0] req
  );
    logic [1:0] idx;
    idx = 2'd3;
    priority case (1'b1)
      req[0]:  idx = 2'd0;
      req[1]:  idx = 2'd1;
      req[2]:  idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] soft_cause(
    input logic [1:0] idx
  );
    return {1'b1, idx};
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asynchronous assert, synchronous release.
// Ports: i_clk, i_rst_n (raw), o_pre (stage 1), o_sync (stage 2).
module reset_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_pre,
  output logic o_sync
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign o_pre  = r_sync[0];
  assign o_sync = r_sync[1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Staged reset sequencer: POR release io -> core -> user, plus soft resets.
// Ports: clk, resetb, soft_req/soft_ack, rstb_io/core/user, busy, rst_cause.
module reset_seq_ctrl
  import fsic_pkg::*;
#(
  parameter int DLY_IO   = 4,
  parameter int DLY_CORE = 8,
  parameter int DLY_USER = 16,
  parameter int HOLD     = 8,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [N_REQ-1:0] soft_req,
  output logic [N_REQ-1:0] soft_ack,
  output logic             rstb_io,
  output logic             rstb_core,
  output logic             rstb_user,
  output logic             busy,
  output logic [2:0]       rst_cause
);

  localparam logic [CNT_W-1:0] L_IO   = CNT_W'(DLY_IO);
  localparam logic [CNT_W-1:0] L_CORE = CNT_W'(DLY_CORE);
  localparam logic [CNT_W-1:0] L_USER = CNT_W'(DLY_USER);
  localparam logic [CNT_W-1:0] L_HOLD = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

  logic w_pre;
  logic w_sync;

  reset_sync u_sync (
    .i_clk   (clk),
    .i_rst_n (resetb),
    .o_pre   (w_pre),
    .o_sync  (w_sync)
  );

  rst_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_io;
  logic             r_core;
  logic             r_user;
  logic             r_busy;
  logic [N_REQ-1:0] r_ack;
  logic [2:0]       r_cause;

  rst_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_io_nxt;
  logic             w_core_nxt;
  logic             w_user_nxt;
  logic [N_REQ-1:0] w_ack_nxt;
  logic [2:0]       w_cause_nxt;
  logic [1:0]       w_idx;
  logic             w_tc;

  assign w_idx = prio_idx(soft_req);
  assign w_tc  = (r_cnt == L_ONE);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= ST_SYNC;
      r_cnt   <= '0;
      r_io    <= 1'b0;
      r_core  <= 1'b0;
      r_user  <= 1'b0;
      r_busy  <= 1'b1;
      r_ack   <= '0;
      r_cause <= CAUSE_POR;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_io    <= w_io_nxt;
      r_core  <= w_core_nxt;
      r_user  <= w_user_nxt;
      r_busy  <= (w_state_nxt != ST_RUN);
      r_ack   <= w_ack_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_io_nxt    = r_io;
    w_core_nxt  = r_core;
    w_user_nxt  = r_user;
    w_ack_nxt   = '0;
    w_cause_nxt = r_cause;
    unique case (r_state)
      ST_SYNC: begin
        // Leave on the edge where the release lands in stage 2,
        // so that edge is the sequence origin.
        if (w_pre && !w_sync) begin
          w_state_nxt = ST_WAIT_IO;
          w_cnt_nxt   = L_IO;
        end
      end
      ST_WAIT_IO: begin
        if (w_tc) begin
          w_io_nxt    = 1'b1;
          w_cnt_nxt   = L_CORE;
          w_state_nxt = ST_WAIT_CORE;
        end else begin
          w_cnt_nxt = r_cnt - L_ONE;
        end
      end
      ST_WAIT_CORE: begin
        if (w_tc) begin
          w_core_nxt  = 1'b1;
          w_cnt_nxt   = L_USER;
          w_state_nxt = ST_WAIT_USER;
        end else begin
          w_cnt_nxt = r_cnt - L_ONE;
        end
      end
      ST_WAIT_USER: begin
        if (w_tc) begin
          w_user_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - L_ONE;
        end
      end
      ST_RUN: begin
        if (|soft_req) begin
          w_ack_nxt   = N_REQ'(1) << w_idx;
          w_cause_nxt = soft_cause(w_idx);
          w_io_nxt    = 1'b0;
          w_core_nxt  = 1'b0;
          w_user_nxt  = 1'b0;
          w_cnt_nxt   = L_HOLD;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Exit edge doubles as the origin of the re-release.
        if (w_tc) begin
          w_cnt_nxt   = L_IO;
          w_state_nxt = ST_WAIT_IO;
        end else begin
          w_cnt_nxt = r_cnt - L_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_SYNC;
        w_cnt_nxt   = '0;
        w_io_nxt    = 1'b0;
        w_core_nxt  = 1'b0;
        w_user_nxt  = 1'b0;
      end
    endcase
  end

  assign soft_ack  = r_ack;
  assign rstb_io   = r_io;
  assign rstb_core = r_core;
  assign rstb_user = r_user;
  assign busy      = r_busy;
  assign rst_cause = r_cause;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl: default and minimum-delay instances.
// Observation word: {io, core, user, busy, ack[3:0], cause[2:0]}.
module tb_reset_seq_ctrl;

  logic       clk;
  logic [1:0] rb;
  logic [3:0] req [2];
  logic [1:0] io_o, core_o, user_o, busy_o;
  logic [3:0] ack_o [2];
  logic [2:0] cause_o [2];

  int n_cmp;
  int n_bad;

  reset_seq_ctrl u_dut0 (
    .clk       (clk),
    .resetb    (rb[0]),
    .soft_req  (req[0]),
    .soft_ack  (ack_o[0]),
    .rstb_io   (io_o[0]),
    .rstb_core (core_o[0]),
    .rstb_user (user_o[0]),
    .busy      (busy_o[0]),
    .rst_cause (cause_o[0])
  );

  reset_seq_ctrl #(
    .DLY_IO   (1),
    .DLY_CORE (1),
    .DLY_USER (1),
    .HOLD     (1),
    .CNT_W    (5)
  ) u_dut1 (
    .clk       (clk),
    .resetb    (rb[1]),
    .soft_req  (req[1]),
    .soft_ack  (ack_o[1]),
    .rstb_io   (io_o[1]),
    .rstb_core (core_o[1]),
    .rstb_user (user_o[1]),
    .busy      (busy_o[1]),
    .rst_cause (cause_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] obs(input int s);
    return {io_o[s], core_o[s], user_o[s], busy_o[s],
            ack_o[s], cause_o[s]};
  endfunction

  // Assert reset, check reset values, release; returns after T0.
  task automatic test_reset(input int s, input string tag);
    logic [10:0] exp;
    rb[s] = 1'b0;
    @(negedge clk);
    exp = {3'b000, 1'b1, 4'b0000, 3'b000};
    n_cmp++;
    if (obs(s) !== exp) begin
      n_bad++;
      $display("FAIL %s reset got=%b want=%b", tag, obs(s), exp);
    end
    rb[s] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Walk the release sequence from k=0 (just after T0) to RUN entry.
  task automatic test_seq(input int s, input int dio, input int dc,
                          input int du, input logic [2:0] cause,
                          input int pk, input string tag);
    int t1, t2, t3;
    logic [10:0] exp;
    t1 = dio;
    t2 = dio + dc;
    t3 = dio + dc + du;
    for (int k = 0; k <= t3; k++) begin
      exp = {(k >= t1), (k >= t2), (k >= t3), (k < t3),
             4'b0000, cause};
      n_cmp++;
      if (obs(s) !== exp) begin
        n_bad++;
        $display("FAIL %s k=%0d got=%b want=%b",
                 tag, k, obs(s), exp);
      end
      if (k == pk) req[s] = 4'hf;
      else if (k == pk + 1) req[s] = 4'h0;
      if (k < t3) @(negedge clk);
    end
  endtask

  // From RUN: request, check grant and hold; returns at next T0.
  task automatic test_grant(input int s, input logic [3:0] rv,
                            input logic [3:0] kv,
                            input logic [3:0] ea,
                            input logic [2:0] ec,
                            input int hold, input string tag);
    logic [10:0] exp;
    req[s] = rv;
    @(posedge clk);
    @(negedge clk);
    exp = {3'b000, 1'b1, ea, ec};
    n_cmp++;
    if (obs(s) !== exp) begin
      n_bad++;
      $display("FAIL %s grant got=%b want=%b", tag, obs(s), exp);
    end
    req[s] = kv;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      exp = {3'b000, 1'b1, 4'b0000, ec};
      n_cmp++;
      if (obs(s) !== exp) begin
        n_bad++;
        $display("FAIL %s hold%0d got=%b want=%b",
                 tag, i, obs(s), exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_soft_single();
    test_grant(0, 4'b0100, 4'b0000, 4'b0100, 3'b110, 8, "soft2");
    test_seq(0, 4, 8, 16, 3'b110, 6, "soft2_seq_pulse");
  endtask

  task automatic test_back_to_back();
    test_grant(0, 4'b1010, 4'b1000, 4'b0010, 3'b101, 8, "pri1");
    test_seq(0, 4, 8, 16, 3'b101, -10, "pri1_seq");
    test_grant(0, 4'b1000, 4'b0000, 4'b1000, 3'b111, 8, "pri3");
    test_seq(0, 4, 8, 16, 3'b111, -10, "pri3_seq");
  endtask

  task automatic test_async_reset();
    logic [10:0] exp;
    req[0] = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    exp = {3'b000, 1'b1, 4'b0001, 3'b100};
    n_cmp++;
    if (obs(0) !== exp) begin
      n_bad++;
      $display("FAIL ar_grant got=%b want=%b", obs(0), exp);
    end
    req[0] = 4'b0000;
    repeat (2) @(negedge clk);
    rb[0] = 1'b0;
    #1;
    exp = {3'b000, 1'b1, 4'b0000, 3'b000};
    n_cmp++;
    if (obs(0) !== exp) begin
      n_bad++;
      $display("FAIL ar_hold got=%b want=%b", obs(0), exp);
    end
    test_reset(0, "ar_por");
    repeat (14) @(negedge clk);
    exp = {3'b110, 1'b1, 4'b0000, 3'b000};
    n_cmp++;
    if (obs(0) !== exp) begin
      n_bad++;
      $display("FAIL ar_mid_pre got=%b want=%b", obs(0), exp);
    end
    rb[0] = 1'b0;
    #1;
    exp = {3'b000, 1'b1, 4'b0000, 3'b000};
    n_cmp++;
    if (obs(0) !== exp) begin
      n_bad++;
      $display("FAIL ar_mid got=%b want=%b", obs(0), exp);
    end
    test_reset(0, "ar_por2");
    test_seq(0, 4, 8, 16, 3'b000, -10, "ar_seq");
  endtask

  task automatic test_min_params();
    test_reset(1, "min_reset");
    test_seq(1, 1, 1, 1, 3'b000, -10, "min_por");
    test_grant(1, 4'b0100, 4'b0000, 4'b0100, 3'b110, 1, "min_soft");
    test_seq(1, 1, 1, 1, 3'b110, -10, "min_soft_seq");
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rb     = 2'b00;
    req[0] = 4'h0;
    req[1] = 4'h0;
    repeat (2) @(negedge clk);
    test_reset(0, "por");
    test_seq(0, 4, 8, 16, 3'b000, -10, "por_seq");
    test_soft_single();
    test_back_to_back();
    test_async_reset();
    test_min_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_seq_ctrl.md
RESET_SEQ_CTRL -- requirements
Module: reset_seq_ctrl

Interface
REQ-001 Parameter DLY_IO, default 4: cycles from sync-reset release to rstb_io high.
REQ-002 Parameter DLY_CORE, default 8: cycles from rstb_io high to rstb_core high.
REQ-003 Parameter DLY_USER, default 16: cycles from rstb_core high to rstb_user high.
REQ-004 Parameter HOLD, default 8: cycles all reset outputs stay low for a soft reset.
REQ-005 Parameter CNT_W, default 5: delay counter width; each delay and HOLD SHALL be ≥1 and ≤2^CNT_W-1.
REQ-006 clk  input  1  single block clock.
REQ-007 resetb  input  1  asynchronous active-low reset from the POR pad path.
REQ-008 soft_req  input  4  per-requester soft-reset request, level, [0]=highest priority.
REQ-009 soft_ack  output  4  one-cycle grant pulse to the serviced requester.
REQ-010 rstb_io  output  1  active-low IO-domain reset.
REQ-011 rstb_core  output  1  active-low core-domain reset.
REQ-012 rstb_user  output  1  active-low user-project reset.
REQ-013 busy  output  1  high whenever the state is not RUN.
REQ-014 rst_cause  output  3  000 = POR; 1ii = soft reset granted to requester ii.

Function
REQ-015 resetb SHALL be synchronised by a 2-flop synchroniser: asynchronous assertion, deassertion visible on the 2nd clk rising edge after resetb rises (T0).
REQ-016 FSM states SHALL be: SYNC, WAIT_IO, WAIT_CORE, WAIT_USER, RUN, HOLD.
REQ-017 SYNC -> WAIT_IO at T0; counter loads DLY_IO.
REQ-018 Each WAIT state SHALL decrement the counter per cycle; at terminal count set its output high and load the next delay: rstb_io high at T0+DLY_IO, rstb_core at T0+DLY_IO+DLY_CORE, rstb_user at T0+DLY_IO+DLY_CORE+DLY_USER, then enter RUN.
REQ-019 Once released, an output SHALL stay high until resetb assertion or HOLD entry.
REQ-020 In RUN, any nonzero soft_req SHALL be granted on that edge to the lowest set index: soft_ack bit pulses next cycle, rst_cause <= {1,index}, state -> HOLD.
REQ-021 In HOLD, all three rstb outputs SHALL be low from the cycle after grant for exactly HOLD cycles; then -> WAIT_IO with the HOLD-exit edge as T0.
REQ-022 soft_req SHALL be ignored (not latched, no ack) outside RUN; a still-asserted request is re-granted on RUN entry.
REQ-023 Simultaneous requests: only the highest-priority one is acked; others wait for the next RUN.
REQ-024 resetb assertion in any state (incl. mid-HOLD or mid-sequence) SHALL immediately force SYNC, all rstb low, soft_ack 0, rst_cause 000.
REQ-025 Outputs SHALL be registered; no combinational path from soft_req to any output.

Reset
REQ-026 On resetb low: state SYNC, synchroniser 00, counter 0, rstb_io/core/user 0, soft_ack 0, busy 1, rst_cause 000.
REQ-027 rst_cause SHALL retain its value through HOLD and the release sequence until the next reset event.

Structure
REQ-028 State encoding and rst_cause encodings SHALL live in the shared fsic package; delay parameters remain module parameters.
REQ-029 The 2-flop synchroniser SHALL be one sub-module, reset_sync.

Verification
REQ-030 resetb rises, defaults -> rstb_io high T0+4, rstb_core T0+12, rstb_user T0+28, busy low T0+28, rst_cause 000.
REQ-031 In RUN, soft_req=4'b0100 -> soft_ack=4'b0100 for one cycle, rst_cause=110, all rstb low 8 cycles, then sequence repeats with 4/12/28 offsets.
REQ-032 In RUN, soft_req=4'b1010 -> soft_ack=4'b0010, rst_cause=101; bit3 held -> granted on next RUN entry, rst_cause=111.
REQ-033 soft_req pulsed during WAIT_CORE -> no ack, sequence timing unchanged.
REQ-034 resetb low 3 cycles into HOLD -> outputs low immediately, rst_cause 000, after release full POR sequence from SYNC.
REQ-035 Parameters DLY_IO=1, DLY_CORE=1, DLY_USER=1, HOLD=1 -> outputs release at T0+1, +2, +3; soft reset holds low exactly 1 cycle.
